// File: rtl/carry_lookahead_adder2.sv
// Registered two-level carry-lookahead adder: 4-bit lookahead groups feeding a
// group-level lookahead unit, with carry-out and signed-overflow flags.
module carry_lookahead_adder2 #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             Cin,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             posOverflow,
   output logic             negOverflow
);

   localparam int unsigned NGRP = WIDTH / 4;
   localparam int unsigned MSB  = WIDTH - 1;

   logic [WIDTH-1:0] w_g;
   logic [WIDTH-1:0] w_p;
   logic [WIDTH-1:0] w_c;
   logic [WIDTH-1:0] w_sum;
   logic [NGRP-1:0]  w_grp_g;
   logic [NGRP-1:0]  w_grp_p;
   logic [NGRP:0]    w_grp_c;
   logic             w_pos_ovf;
   logic             w_neg_ovf;

   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_pos_ovf;
   logic             r_neg_ovf;

   assign w_g = a & b;
   assign w_p = a ^ b;

   // Level 1: in-group carries and group generate/propagate, all explicit lookahead.
   for (genvar k = 0; k < NGRP; k++) begin : g_grp
      localparam int unsigned BASE = 4 * k;
      logic [3:0] w_gk;
      logic [3:0] w_pk;
      logic       w_c0;

      assign w_gk = w_g[BASE +: 4];
      assign w_pk = w_p[BASE +: 4];
      assign w_c0 = w_grp_c[k];

      assign w_c[BASE]     = w_c0;
      assign w_c[BASE + 1] = w_gk[0] | (w_pk[0] & w_c0);
      assign w_c[BASE + 2] = w_gk[1] | (w_pk[1] & w_gk[0])
                           | (w_pk[1] & w_pk[0] & w_c0);
      assign w_c[BASE + 3] = w_gk[2] | (w_pk[2] & w_gk[1])
                           | (w_pk[2] & w_pk[1] & w_gk[0])
                           | (w_pk[2] & w_pk[1] & w_pk[0] & w_c0);

      assign w_grp_g[k] = w_gk[3] | (w_pk[3] & w_gk[2])
                        | (w_pk[3] & w_pk[2] & w_gk[1])
                        | (w_pk[3] & w_pk[2] & w_pk[1] & w_gk[0]);
      assign w_grp_p[k] = &w_pk;
   end

   // Level 2: each group carry-in is a flat sum of products of group G/P and Cin.
   always_comb begin
      logic v_acc;
      logic v_term;
      w_grp_c    = '0;
      w_grp_c[0] = Cin;
      for (int k = 1; k <= int'(NGRP); k++) begin
         v_acc  = 1'b0;
         v_term = Cin;
         for (int m = 0; m < k; m++) begin
            v_term = v_term & w_grp_p[m];
         end
         v_acc = v_acc | v_term;
         for (int j = 0; j < k; j++) begin
            v_term = w_grp_g[j];
            for (int m = j + 1; m < k; m++) begin
               v_term = v_term & w_grp_p[m];
            end
            v_acc = v_acc | v_term;
         end
         w_grp_c[k] = v_acc;
      end
   end

   assign w_sum     = w_p ^ w_c;
   assign w_pos_ovf = ~a[MSB] & ~b[MSB] &  w_sum[MSB];
   assign w_neg_ovf =  a[MSB] &  b[MSB] & ~w_sum[MSB];

   // Output pipeline register; reset wins over capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum     <= '0;
         r_cout    <= 1'b0;
         r_pos_ovf <= 1'b0;
         r_neg_ovf <= 1'b0;
      end else begin
         r_sum     <= w_sum;
         r_cout    <= w_grp_c[NGRP];
         r_pos_ovf <= w_pos_ovf;
         r_neg_ovf <= w_neg_ovf;
      end
   end

   assign S           = r_sum;
   assign Cout        = r_cout;
   assign posOverflow = r_pos_ovf;
   assign negOverflow = r_neg_ovf;

endmodule

// File: tb/tb_carry_lookahead_adder2.sv
// Self-checking bench for carry_lookahead_adder2: directed table, reset,
// back-to-back latency/hold sequence and random vectors against an arithmetic model.
module tb_carry_lookahead_adder2;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a;
   logic [31:0] b;
   logic        Cin;
   logic [31:0] S;
   logic        Cout;
   logic        posOverflow;
   logic        negOverflow;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   carry_lookahead_adder2 #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .a           (a),
      .b           (b),
      .Cin         (Cin),
      .S           (S),
      .Cout        (Cout),
      .posOverflow (posOverflow),
      .negOverflow (negOverflow)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] s;
      logic        cout;
      logic        pos;
      logic        neg;
      string       name;
   } vec_t;

   vec_t tbl[14];

   // Reference: unsigned 33-bit sum for S/Cout, true signed sum range for overflow.
   function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic c,
                                 output logic [31:0] s, output logic co,
                                 output logic po, output logic no);
      logic [32:0] u;
      longint      t;
      u  = {1'b0, x} + {1'b0, y} + 33'(c);
      s  = u[31:0];
      co = u[32];
      t  = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
      po = (t > longint'(32'h7fff_ffff));
      no = (t < -longint'(32'h8000_0000));
   endfunction

   task automatic check(input string name, input logic [31:0] es, input logic ec,
                        input logic ep, input logic en);
      n_vec++;
      if (S !== es || Cout !== ec || posOverflow !== ep || negOverflow !== en) begin
         n_err++;
         $display("FAIL %s: got S=%h Cout=%b pos=%b neg=%b, expected S=%h Cout=%b pos=%b neg=%b",
                  name, S, Cout, posOverflow, negOverflow, es, ec, ep, en);
      end
   endtask

   task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic c);
      a   = x;
      b   = y;
      Cin = c;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] ex_s, ex_s_nxt;
   logic        ex_c, ex_p, ex_n, ex_c_nxt, ex_p_nxt, ex_n_nxt;
   logic [31:0] ra, rb, na, nb;
   logic        rc, nc;

   initial begin
      tbl[0]  = '{32'h7fff_ffff, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "max_plus_one"};
      tbl[1]  = '{32'h8000_0000, 32'hffff_ffff, 1'b0, 32'h7fff_ffff, 1'b1, 1'b0, 1'b1, "min_minus_one"};
      tbl[2]  = '{32'h0000_0005, 32'hffff_fffd, 1'b0, 32'h0000_0002, 1'b1, 1'b0, 1'b0, "5_plus_m3"};
      tbl[3]  = '{32'hffff_fff6, 32'hffff_fff8, 1'b0, 32'hffff_ffee, 1'b1, 1'b0, 1'b0, "m10_plus_m8"};
      tbl[4]  = '{32'd100,       32'd50,        1'b1, 32'd151,       1'b0, 1'b0, 1'b0, "cin_100_50"};
      tbl[5]  = '{32'hffff_ffe2, 32'd40,        1'b1, 32'd11,        1'b1, 1'b0, 1'b0, "cin_m30_40"};
      tbl[6]  = '{32'h0,         32'h0,         1'b1, 32'h1,         1'b0, 1'b0, 1'b0, "cin_zero"};
      tbl[7]  = '{32'hffff_ffff, 32'h0,         1'b1, 32'h0,         1'b1, 1'b0, 1'b0, "cin_all_prop"};
      tbl[8]  = '{32'h7fff_ffff, 32'h0,         1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "cin_pos_ovf"};
      tbl[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, "min_plus_min"};
      tbl[10] = '{32'hffff_ffff, 32'hffff_ffff, 1'b1, 32'hffff_ffff, 1'b1, 1'b0, 1'b0, "all_ones_cin"};
      tbl[11] = '{32'h0,         32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 1'b0, "zero"};
      tbl[12] = '{32'h0000_000f, 32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0, 1'b0, 1'b0, "group_boundary"};
      tbl[13] = '{32'h0fff_ffff, 32'h0000_0000, 1'b1, 32'h1000_0000, 1'b0, 1'b0, 1'b0, "grp_chain_cin"};

      // Reset with operands that would otherwise give a nonzero, overflowing result.
      rst = 1'b1;
      drive(32'h7fff_ffff, 32'h0000_0001, 1'b1);
      step();
      check("reset", 32'h0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;

      foreach (tbl[i]) begin
         drive(tbl[i].a, tbl[i].b, tbl[i].cin);
         step();
         check(tbl[i].name, tbl[i].s, tbl[i].cout, tbl[i].pos, tbl[i].neg);
      end

      // Reset priority over a capture after the register holds a nonzero value.
      drive(32'h8000_0000, 32'hffff_ffff, 1'b0);
      step();
      check("pre_reset", 32'h7fff_ffff, 1'b1, 1'b0, 1'b1);
      rst = 1'b1;
      step();
      check("reset_priority", 32'h0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;

      // Back-to-back: new operands every cycle; outputs hold between edges.
      ra = $urandom; rb = $urandom; rc = 1'($urandom);
      for (int i = 0; i < 20; i++) begin
         drive(ra, rb, rc);
         model(ra, rb, rc, ex_s, ex_c, ex_p, ex_n);
         step();
         check("b2b", ex_s, ex_c, ex_p, ex_n);
         na = $urandom; nb = $urandom; nc = 1'($urandom);
         model(na, nb, nc, ex_s_nxt, ex_c_nxt, ex_p_nxt, ex_n_nxt);
         drive(na, nb, nc);
         #1;
         if ({ex_s_nxt, ex_c_nxt, ex_p_nxt, ex_n_nxt} != {ex_s, ex_c, ex_p, ex_n})
            check("b2b_hold", ex_s, ex_c, ex_p, ex_n);
         ra = na; rb = nb; rc = nc;
      end

      // Random operands, biased to hit sign-boundary and propagate-heavy cases.
      for (int i = 0; i < 400; i++) begin
         ra = $urandom;
         rb = $urandom;
         rc = 1'($urandom);
         case ($urandom_range(0, 3))
            0: rb = ~ra;
            1: begin ra[31] = 1'b0; rb[31] = 1'b0; end
            2: begin ra[31] = 1'b1; rb[31] = 1'b1; end
            default: ;
         endcase
         drive(ra, rb, rc);
         model(ra, rb, rc, ex_s, ex_c, ex_p, ex_n);
         step();
         check("random", ex_s, ex_c, ex_p, ex_n);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
